fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Parametrised framebuffer write front-end sitting between pixel producers (execWrite-style engines, key-driven cursors) and the display_if write port (mem_waddr/mem_wdata/mem_web).
- Arbitrates NCH independent pixel-write request channels round-robin and converts (col,row) to a linear address.
- Adds a hardware clear/fill mode that sweeps the whole COLS x ROWS grid, one pixel per cycle.

Parameters:
- COLS, 80, grid width in pixels.
- ROWS, 60, grid height in pixels.
- COL_W, 7, column coordinate width; must satisfy 2^COL_W >= COLS.
- ROW_W, 6, row coordinate width; must satisfy 2^ROW_W >= ROWS.
- ADDR_W, 13, address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- DATA_W, 24, pixel data width (RGB 8:8:8).
- NCH, 2, number of request channels, 1..8.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel write request.
- req_ready  out  NCH  per-channel grant; combinational from state and arbiter pointer.
- req_col  in  NCH*COL_W  packed column; channel i at [i*COL_W +: COL_W].
- req_row  in  NCH*ROW_W  packed row.
- req_data  in  NCH*DATA_W  packed pixel data.
- clear_start  in  1  one-cycle pulse; begins a full-grid fill.
- clear_color  in  DATA_W  fill value; sampled on the accepted clear_start.
- busy  out  1  high while a clear is in progress.
- clear_done  out  1  one-cycle pulse after the last fill write is issued.
- oob_err  out  1  one-cycle pulse when an accepted request has col>=COLS or row>=ROWS.
- mem_waddr  out  ADDR_W  write address, computed as row*COLS+col.
- mem_wdata  out  DATA_W  write data.
- mem_web  out  1  write enable; one cycle per write.

Behaviour:
- Reset values:
  - mem_web, mem_waddr, mem_wdata, busy, clear_done, oob_err are all 0.
  - State is IDLE.
  - Round-robin pointer is 0.
  - Clear counters are 0.
- All outputs except req_ready are registered.
- Handshake:
  - A transfer on channel i occurs when req_valid[i] && req_ready[i] at a clock edge.
  - The corresponding mem_web pulse appears on the next cycle: latency 1.
  - At most one grant per cycle; throughput is 1 write per cycle.
- Arbitration (IDLE only):
  - Grant the first valid channel at or after the pointer, searching cyclically.
  - After a grant to channel g, the pointer becomes (g+1) mod NCH.
  - With no valid requests, the pointer holds.
  - req_ready is one-hot or zero and never depends on req_data.
- Out of range: the request is still accepted (ready asserted), mem_web stays 0, and oob_err pulses on the cycle the write would have appeared.
- State machine:
  - IDLE: arbitrate requests. If clear_start is asserted, move to CLEAR; clear_start has priority over requests that cycle, and all req_ready are 0.
  - CLEAR:
    - All req_ready are 0; busy=1.
    - Each cycle, issue a write at (ccol,crow) with the latched colour.
    - ccol increments and wraps at COLS-1 to 0, which increments crow.
    - After (COLS-1, ROWS-1) is issued, return to IDLE and pulse clear_done in the cycle following that last write's mem_web.
    - A clear takes exactly COLS*ROWS cycles of mem_web.
    - clear_start during CLEAR is ignored.
  - busy rises the cycle after clear_start and falls together with the clear_done pulse.
- Address arithmetic:
  - row*COLS is computed at ADDR_W width; no truncation is possible under the parameter constraints.
  - The last address is COLS*ROWS-1 (4799 at defaults).
- Reset mid-clear: the sweep aborts immediately, state goes to IDLE, clear_done does not pulse, and the next cycle shows mem_web=0.
- Simultaneous clear_start and requests in IDLE: requests are not granted; they stay pending and are served after the clear.

Decomposition:
- Shared package fb_pkg holds:
  - Default COLS/ROWS/DATA_W constants.
  - A state enum {IDLE, CLEAR}.
  - An address function addr_of(row,col).
- Natural sub-module: rr_arbiter (parametrised NCH; inputs req vector and advance; outputs one-hot grant and pointer). It is reused by later multi-master memory blocks.

Test Plan:
1. Single write: after reset, NCH=2; ch0 valid col=5,row=3,data=24'hFF0000. Required: ready[0] asserted that cycle; the next cycle shows mem_web=1, mem_waddr=245, mem_wdata=FF0000.
2. Round-robin: ch0 and ch1 both held valid for 4 cycles. Required: grants alternate 0,1,0,1 and mem_web stays high 4 consecutive cycles. Also check a solo ch1 request followed by both valid: the grant after ch1 goes to ch0.
3. Clear:
   - Stimulus: clear_start with clear_color=24'h00FF00.
   - Required: busy=1; exactly 4800 mem_web pulses with addresses 0..4799 in order, all data 00FF00; clear_done pulses once; busy falls.
   - Required: a ch0 request held during the clear is not ready until busy is 0, then it is served.
4. Out of range: ch1 col=80,row=0 (also col=0,row=60). Required: ready asserted, mem_web=0, oob_err pulses 1 cycle later.
5. Reset mid-clear: rst asserted at fill write 1000. Required: the next cycle has mem_web=0, busy=0, and no clear_done. A new clear_start restarts at address 0.
6. Boundary: clear_start asserted again during CLEAR is ignored, giving a total of 4800 writes. An explicit write to col=79,row=59 yields addr 4799.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default grid geometry, scheduler state
// encoding and the linear address helper.
package fb_pkg;

  localparam int FB_COLS   = 80;
  localparam int FB_ROWS   = 60;
  localparam int FB_DATA_W = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Row-major linear address; callers cast the result to their address width.
  function automatic int unsigned addr_of(input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned cols = FB_COLS);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves past the winner only when the grant is used.
module rr_arbiter #(
  parameter int NCH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NCH-1:0]                           req,
  input  logic                                     advance,
  output logic [NCH-1:0]                           grant,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ptr
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant    = '0;
    ptr_next = ptr_reg;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == NCH - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write front-end: round-robin pixel write channels plus a
// full-grid hardware fill, driving a single registered memory write port.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int COLS   = FB_COLS,
  parameter int ROWS   = FB_ROWS,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 13,
  parameter int DATA_W = FB_DATA_W,
  parameter int NCH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          req_valid,
  output logic [NCH-1:0]          req_ready,
  input  logic [NCH*COL_W-1:0]    req_col,
  input  logic [NCH*ROW_W-1:0]    req_row,
  input  logic [NCH*DATA_W-1:0]   req_data,
  input  logic                    clear_start,
  input  logic [DATA_W-1:0]       clear_color,
  output logic                    busy,
  output logic                    clear_done,
  output logic                    oob_err,
  output logic [ADDR_W-1:0]       mem_waddr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_web
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  fb_state_t state_reg, state_next;

  logic [COL_W-1:0]  ccol_reg;
  logic [ROW_W-1:0]  crow_reg;
  logic [DATA_W-1:0] color_reg;
  logic              busy_reg, done_pend_reg, clear_done_reg, oob_err_reg;
  logic              mem_web_reg;
  logic [ADDR_W-1:0] mem_waddr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic [NCH-1:0]    grant;
  logic [PTR_W-1:0]  arb_ptr;
  logic              advance, clear_go, last_fill, sel_oob;
  logic [COL_W-1:0]  sel_col;
  logic [ROW_W-1:0]  sel_row;
  logic [DATA_W-1:0] sel_data;

  logic [COL_W-1:0]  ch_col  [NCH];
  logic [ROW_W-1:0]  ch_row  [NCH];
  logic [DATA_W-1:0] ch_data [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_col[gi]  = req_col[gi*COL_W +: COL_W];
      assign ch_row[gi]  = req_row[gi*ROW_W +: ROW_W];
      assign ch_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant),
    .ptr     (arb_ptr)
  );

  always_comb begin
    sel_col  = '0;
    sel_row  = '0;
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) begin
        sel_col  = ch_col[k];
        sel_row  = ch_row[k];
        sel_data = ch_data[k];
      end
    end
  end

  assign sel_oob   = (int'(sel_col) >= COLS) || (int'(sel_row) >= ROWS);
  assign last_fill = (int'(ccol_reg) == COLS - 1) && (int'(crow_reg) == ROWS - 1);
  // busy_reg also covers the tail cycle after the sweep returns to IDLE
  assign clear_go  = (state_reg == IDLE) && !busy_reg && clear_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (clear_go)  state_next = CLEAR;
      CLEAR:   if (last_fill) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if ((state_reg == IDLE) && !busy_reg && !clear_start) begin
      req_ready = grant;
    end
    advance = |(req_valid & req_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccol_reg       <= '0;
      crow_reg       <= '0;
      color_reg      <= '0;
      busy_reg       <= 1'b0;
      done_pend_reg  <= 1'b0;
      clear_done_reg <= 1'b0;
      oob_err_reg    <= 1'b0;
      mem_web_reg    <= 1'b0;
      mem_waddr_reg  <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      mem_web_reg    <= 1'b0;
      oob_err_reg    <= 1'b0;
      done_pend_reg  <= 1'b0;
      clear_done_reg <= done_pend_reg;
      if (done_pend_reg) busy_reg <= 1'b0;

      if (clear_go) begin
        busy_reg  <= 1'b1;
        color_reg <= clear_color;
        ccol_reg  <= '0;
        crow_reg  <= '0;
      end

      if (state_reg == CLEAR) begin
        mem_web_reg   <= 1'b1;
        mem_waddr_reg <= ADDR_W'(addr_of(int'(crow_reg), int'(ccol_reg), COLS));
        mem_wdata_reg <= color_reg;
        done_pend_reg <= last_fill;
        if (int'(ccol_reg) == COLS - 1) begin
          ccol_reg <= '0;
          crow_reg <= last_fill ? '0 : crow_reg + 1'b1;
        end else begin
          ccol_reg <= ccol_reg + 1'b1;
        end
      end else if (advance) begin
        // Out-of-range requests are consumed but never reach memory
        if (sel_oob) begin
          oob_err_reg <= 1'b1;
        end else begin
          mem_web_reg   <= 1'b1;
          mem_waddr_reg <= ADDR_W'(addr_of(int'(sel_row), int'(sel_col), COLS));
          mem_wdata_reg <= sel_data;
        end
      end
    end
  end

  assign busy       = busy_reg;
  assign clear_done = clear_done_reg;
  assign oob_err    = oob_err_reg;
  assign mem_web    = mem_web_reg;
  assign mem_waddr  = mem_waddr_reg;
  assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench: stimulus queues expected writes/oob/done events with
// their cycle stamps; a negedge monitor pops and compares them.
module tb_fb_write_scheduler;

  localparam int COLS = 80, ROWS = 60, COL_W = 7, ROW_W = 6;
  localparam int ADDR_W = 13, DATA_W = 24, NCH = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NCH-1:0]        req_valid, req_ready;
  logic [NCH*COL_W-1:0]  req_col;
  logic [NCH*ROW_W-1:0]  req_row;
  logic [NCH*DATA_W-1:0] req_data;
  logic                  clear_start;
  logic [DATA_W-1:0]     clear_color;
  logic                  busy, clear_done, oob_err, mem_web;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;

  fb_write_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .req_row(req_row), .req_data(req_data),
    .clear_start(clear_start), .clear_color(clear_color), .busy(busy),
    .clear_done(clear_done), .oob_err(oob_err), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_web(mem_web)
  );

  typedef struct {
    int          addr;
    logic [23:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_q[$];
  int  oob_q[$];
  int  done_q[$];
  int  checks = 0, errors = 0, cyc = 0, done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event, value 0x%0h (cycle %0d)", name, act, cyc);
  endtask

  task automatic push_wr(input int addr, input logic [23:0] data, input int c);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    wr_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_web === 1'b1) begin
      if (wr_q.size() == 0) begin
        spurious("write", 64'(mem_waddr));
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 64'(mem_waddr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (oob_err === 1'b1) begin
      if (oob_q.size() == 0) spurious("oob_err", 64'(cyc));
      else chk("oob_cycle", 64'(cyc), 64'(oob_q.pop_front()));
    end
    if (clear_done === 1'b1) begin
      done_cnt++;
      if (done_q.size() == 0) spurious("clear_done", 64'(cyc));
      else chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      chk("busy_with_done", 64'(busy), 64'd0);
    end
  end

  // Single-channel request; caller and return both sit 1 time unit after posedge.
  task automatic issue(input int ch, input int col, input int row,
                       input logic [23:0] data, input bit oob);
    logic [NCH-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[ch] = 1'b1;
    req_valid = exp_rdy;
    req_col[ch*COL_W +: COL_W]    = COL_W'(col);
    req_row[ch*ROW_W +: ROW_W]    = ROW_W'(row);
    req_data[ch*DATA_W +: DATA_W] = data;
    #1;
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    $display("issue ch%0d col=%0d row=%0d data=%06h oob=%0d", ch, col, row, data, oob);
    if (oob) oob_q.push_back(cyc + 1);
    else push_wr(row * COLS + col, data, cyc + 1);
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, leak, t;
    logic [NCH-1:0] exp_rdy;
    rst = 1'b1;
    req_valid = '0; req_col = '0; req_row = '0; req_data = '0;
    clear_start = 1'b0; clear_color = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_web", 64'(mem_web), 0);
    chk("rst_waddr", 64'(mem_waddr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(clear_done), 0);
    chk("rst_oob", 64'(oob_err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(0, 5, 3, 24'hFF0000, 1'b0);   // addr 245
    issue(1, 2, 2, 24'h00ABCD, 1'b0);   // addr 162, pointer back to 0

    // Both channels held: grants alternate 0,1,0,1 back to back
    req_valid = 2'b11;
    req_col   = {7'd0, 7'd10};
    req_row   = {6'd1, 6'd0};
    req_data  = {24'h222222, 24'h111111};
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", 64'(req_ready), 64'(exp_rdy));
      $display("rr cycle %0d ready=%b", i, req_ready);
      if (i % 2 == 0) push_wr(10, 24'h111111, cyc + 1);
      else push_wr(80, 24'h222222, cyc + 1);
      @(posedge clk);
      #1;
    end
    req_valid = '0;

    issue(1, 80, 0, 24'h333333, 1'b1);
    issue(1, 0, 60, 24'h444444, 1'b1);
    issue(0, 79, 59, 24'h555555, 1'b0);  // addr 4799

    // Clear with a ch0 request held from the same cycle as clear_start
    req_valid = 2'b01;
    req_col = {7'd0, 7'd1}; req_row = {6'd0, 6'd1}; req_data = {24'h0, 24'hAAAAAA};
    clear_color = 24'h00FF00;
    clear_start = 1'b1;
    base = cyc;
    for (int k = 0; k < COLS * ROWS; k++) push_wr(k, 24'h00FF00, base + 2 + k);
    done_q.push_back(base + 2 + COLS * ROWS);
    #1;
    chk("clear_prio_ready", 64'(req_ready), 0);
    $display("clear 1 started at cycle %0d", base);
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    #1;
    chk("busy_rise", 64'(busy), 1);
    leak = 0;
    t = 0;
    while (busy === 1'b1 && t < 6000) begin
      if (req_ready !== '0) leak++;
      @(posedge clk);
      #2;
      t++;
    end
    chk("busy_fall", 64'(busy), 0);
    chk("ready_leak", 64'(leak), 0);
    chk("ready_after_clear", 64'(req_ready), 64'(2'b01));
    push_wr(81, 24'hAAAAAA, cyc + 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 1);

    // Reset lands right after fill write 999 is issued
    clear_color = 24'h123456;
    clear_start = 1'b1;
    base = cyc;
    for (int k = 0; k < 1000; k++) push_wr(k, 24'h123456, base + 2 + k);
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_web", 64'(mem_web), 0);
    chk("midrst_busy", 64'(busy), 0);
    $display("reset mid-clear at cycle %0d", cyc);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 1);

    // Fresh clear restarts at 0; a second clear_start mid-sweep is ignored
    clear_color = 24'h0F0F0F;
    clear_start = 1'b1;
    base = cyc;
    for (int k = 0; k < COLS * ROWS; k++) push_wr(k, 24'h0F0F0F, base + 2 + k);
    done_q.push_back(base + 2 + COLS * ROWS);
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    t = 0;
    while (busy === 1'b1 && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("busy_fall2", 64'(busy), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("done_count2", 64'(done_cnt), 2);
    chk("wr_q_empty", 64'(wr_q.size()), 0);
    chk("oob_q_empty", 64'(oob_q.size()), 0);
    chk("done_q_empty", 64'(done_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
